// File: rtl/mc_control_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath/memory.
// master = controller (mc_control), slave = datapath/memory side.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic [3:0] contr;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       retire;
  logic       illegal;
  logic       mem_err;

  modport master (
    input  opcode, funct, mem_ready,
    output contr, alu_src_a, alu_src_b, imm_zext, iord, mem_read, mem_write,
           ir_write, pc_write, pc_write_cond, pc_source, reg_dst, mem_to_reg,
           reg_write, retire, illegal, mem_err
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  contr, alu_src_a, alu_src_b, imm_zext, iord, mem_read, mem_write,
           ir_write, pc_write, pc_write_cond, pc_source, reg_dst, mem_to_reg,
           reg_write, retire, illegal, mem_err
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM with memory-ready timeout.
// Define MC_CONTROL_IMM_EN to add addi/slti/andi/ori (IEXEC/IWB states).
module mc_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst_n,
  mc_control_if.master bus
);
  localparam int unsigned   CW       = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [3:0] {
`ifdef MC_CONTROL_IMM_EN
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_IEXEC, S_IWB
`else
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP
`endif
  } state_t;

  state_t        r_state, w_state_next, w_dec_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_op, w_dec_op;
  logic          r_store;
  logic          r_retire, r_illegal, r_mem_err;
  logic          w_dec_illegal, w_wait, w_timeout;
  logic          w_retire_evt, w_illegal_evt;
`ifdef MC_CONTROL_IMM_EN
  logic          r_zext, w_dec_zext;
`endif

  logic [3:0] w_contr;
  logic [1:0] w_alu_src_b, w_pc_source;
  logic       w_alu_src_a, w_imm_zext, w_iord, w_mem_read, w_mem_write;
  logic       w_ir_write, w_pc_write, w_pc_write_cond;
  logic       w_reg_dst, w_mem_to_reg, w_reg_write;

  always_comb begin
    w_dec_op      = ALU_ADD;
    w_dec_next    = S_FETCH;
    w_dec_illegal = 1'b1;
`ifdef MC_CONTROL_IMM_EN
    w_dec_zext    = 1'b0;
`endif
    case (bus.opcode)
      6'h00: begin
        w_dec_next    = S_EXEC;
        w_dec_illegal = 1'b0;
        case (bus.funct)
          6'h20: w_dec_op = ALU_ADD;
          6'h22: w_dec_op = ALU_SUB;
          6'h24: w_dec_op = ALU_AND;
          6'h25: w_dec_op = ALU_OR;
          6'h27: w_dec_op = ALU_NOR;
          6'h2A: w_dec_op = ALU_SLT;
          default: begin
            w_dec_next    = S_FETCH;
            w_dec_illegal = 1'b1;
          end
        endcase
      end
      6'h23, 6'h2B: begin w_dec_next = S_MEMADR; w_dec_illegal = 1'b0; end
      6'h04:        begin w_dec_next = S_BRANCH; w_dec_illegal = 1'b0; end
      6'h02:        begin w_dec_next = S_JUMP;   w_dec_illegal = 1'b0; end
`ifdef MC_CONTROL_IMM_EN
      6'h08: begin w_dec_next = S_IEXEC; w_dec_illegal = 1'b0; w_dec_op = ALU_ADD; end
      6'h0A: begin w_dec_next = S_IEXEC; w_dec_illegal = 1'b0; w_dec_op = ALU_SLT; end
      6'h0C: begin w_dec_next = S_IEXEC; w_dec_illegal = 1'b0; w_dec_op = ALU_AND; w_dec_zext = 1'b1; end
      6'h0D: begin w_dec_next = S_IEXEC; w_dec_illegal = 1'b0; w_dec_op = ALU_OR;  w_dec_zext = 1'b1; end
`endif
      default: ;
    endcase
  end

  // r_cnt holds the number of elapsed cycles without mem_ready; ready on the last one still completes
  assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = w_wait && !bus.mem_ready && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next    = r_state;
    w_contr         = ALU_AND;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_imm_zext      = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = 2'b00;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_retire_evt    = 1'b0;
    w_illegal_evt   = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_contr     = ALU_ADD;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
        if (bus.mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_b   = 2'b11;
        w_contr       = ALU_ADD;
        w_state_next  = w_dec_next;
        w_illegal_evt = w_dec_illegal;
      end
      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_contr      = ALU_ADD;
        w_state_next = r_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready)  w_state_next = S_MEMWB;
        else if (w_timeout) w_state_next = S_FETCH;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire_evt = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready) begin
          w_retire_evt = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          w_state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        w_alu_src_a  = 1'b1;
        w_contr      = r_op;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst    = 1'b1;
        w_reg_write  = 1'b1;
        w_retire_evt = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_contr         = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_retire_evt    = 1'b1;
        w_state_next    = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = 2'b10;
        w_retire_evt = 1'b1;
        w_state_next = S_FETCH;
      end
`ifdef MC_CONTROL_IMM_EN
      S_IEXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_contr      = r_op;
        w_imm_zext   = r_zext;
        w_state_next = S_IWB;
      end
      S_IWB: begin
        w_reg_write  = 1'b1;
        w_retire_evt = 1'b1;
        w_state_next = S_FETCH;
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= ALU_AND;
      r_store   <= 1'b0;
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_retire  <= w_retire_evt;
      r_illegal <= w_illegal_evt;
      r_mem_err <= w_timeout;
      if (r_state == S_DECODE) begin
        r_op    <= w_dec_op;
        r_store <= (bus.opcode == 6'h2B);
      end
    end
  end

`ifdef MC_CONTROL_IMM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                    r_zext <= 1'b0;
    else if (r_state == S_DECODE)  r_zext <= w_dec_zext;
  end
`endif

  // A timeout in FETCH re-enters FETCH, so it must clear the counter like a state change
  always_ff @(posedge clk) begin
    if (!rst_n)                                        r_cnt <= '0;
    else if (w_timeout || (w_state_next != r_state))   r_cnt <= '0;
    else if (w_wait && !bus.mem_ready)                 r_cnt <= r_cnt + CW'(1);
  end

  assign bus.contr         = w_contr;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.imm_zext      = w_imm_zext;
  assign bus.iord          = w_iord;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.pc_source     = w_pc_source;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.reg_write     = w_reg_write;
  assign bus.retire        = r_retire;
  assign bus.illegal       = r_illegal;
  assign bus.mem_err       = r_mem_err;
endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: an instruction-level model emits per-cycle
// stimulus and expected control words; a monitor compares every cycle.
module tb_mc_control;
  localparam int unsigned T = 16;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;
  localparam logic [3:0] A_NOR = 4'b1100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_control_if bus ();
  mc_control #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0] contr;
    logic       src_a;
    logic [1:0] src_b;
    logic       zext;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcsrc;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       ret;
    logic       ill;
    logic       err;
  } ctl_t;

  typedef struct packed {
    logic       rn;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
  } stim_t;

  ctl_t       exp_q[$];
  stim_t      stim_q[$];
  logic       pend_ret = 1'b0, pend_ill = 1'b0, pend_err = 1'b0;
  logic [5:0] cur_op = '0, cur_fn = '0;
  int         checks = 0, errors = 0, cyc = 0;
  bit         running = 1'b0, drv_done = 1'b0, mon_done = 1'b0;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int unsigned pick_delay();
    case ($urandom_range(0, 9))
      5:       return 1;
      6:       return $urandom_range(2, 5);
      7:       return T - 1;
      8:       return T;
      default: return 0;
    endcase
  endfunction

  function automatic ctl_t v_fetch(input logic done);
    ctl_t c = '0;
    c.mrd = 1'b1; c.src_b = 2'b01; c.contr = A_ADD; c.irw = done; c.pcw = done;
    return c;
  endfunction

  function automatic ctl_t v_decode();
    ctl_t c = '0;
    c.src_b = 2'b11; c.contr = A_ADD;
    return c;
  endfunction

  // Pulses flagged by the previous cycle land on the next emitted cycle.
  task automatic emit(input ctl_t c, input logic rdy, input logic rn);
    ctl_t  v;
    stim_t s;
    v = c; v.ret = pend_ret; v.ill = pend_ill; v.err = pend_err;
    pend_ret = 1'b0; pend_ill = 1'b0; pend_err = 1'b0;
    s.rn = rn; s.op = cur_op; s.fn = cur_fn; s.rdy = rdy;
    exp_q.push_back(v);
    stim_q.push_back(s);
  endtask

  // d >= T: the access never sees ready and is abandoned after T cycles
  task automatic mem_wait(input ctl_t busy, input ctl_t done, input int unsigned d, output bit ok);
    if (d >= T) begin
      for (int unsigned i = 0; i < T; i++) emit(busy, 1'b0, 1'b1);
      pend_err = 1'b1;
      ok = 1'b0;
    end else begin
      for (int unsigned i = 0; i < d; i++) emit(busy, 1'b0, 1'b1);
      emit(done, 1'b1, 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic do_fetch(input int unsigned d);
    bit ok;
    mem_wait(v_fetch(1'b0), v_fetch(1'b1), d, ok);
    while (!ok) mem_wait(v_fetch(1'b0), v_fetch(1'b1), pick_delay(), ok);
  endtask

  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int unsigned df, input int unsigned dm);
    ctl_t       c;
    bit         ok;
    logic       valid;
    logic       z;
    logic [3:0] alu;
    cur_op = op; cur_fn = fn;
    do_fetch(df);
    emit(v_decode(), rnd(), 1'b1);
    valid = 1'b0; z = 1'b0; alu = A_ADD;
    case (op)
      6'h00: begin
        valid = 1'b1;
        case (fn)
          6'h20: alu = A_ADD;
          6'h22: alu = A_SUB;
          6'h24: alu = A_AND;
          6'h25: alu = A_OR;
          6'h27: alu = A_NOR;
          6'h2A: alu = A_SLT;
          default: valid = 1'b0;
        endcase
        if (!valid) pend_ill = 1'b1;
        else begin
          c = '0; c.src_a = 1'b1; c.contr = alu; emit(c, rnd(), 1'b1);
          c = '0; c.rdst = 1'b1; c.rw = 1'b1; emit(c, rnd(), 1'b1);
          pend_ret = 1'b1;
        end
      end
      6'h23, 6'h2B: begin
        c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.contr = A_ADD; emit(c, rnd(), 1'b1);
        if (op == 6'h23) begin
          c = '0; c.mrd = 1'b1; c.iord = 1'b1; mem_wait(c, c, dm, ok);
          if (ok) begin
            c = '0; c.m2r = 1'b1; c.rw = 1'b1; emit(c, rnd(), 1'b1);
            pend_ret = 1'b1;
          end
        end else begin
          c = '0; c.mwr = 1'b1; c.iord = 1'b1; mem_wait(c, c, dm, ok);
          if (ok) pend_ret = 1'b1;
        end
      end
      6'h04: begin
        c = '0; c.src_a = 1'b1; c.contr = A_SUB; c.pcwc = 1'b1; c.pcsrc = 2'b01;
        emit(c, rnd(), 1'b1);
        pend_ret = 1'b1;
      end
      6'h02: begin
        c = '0; c.pcw = 1'b1; c.pcsrc = 2'b10; emit(c, rnd(), 1'b1);
        pend_ret = 1'b1;
      end
      default: begin
`ifdef MC_CONTROL_IMM_EN
        case (op)
          6'h08: begin valid = 1'b1; alu = A_ADD; end
          6'h0A: begin valid = 1'b1; alu = A_SLT; end
          6'h0C: begin valid = 1'b1; alu = A_AND; z = 1'b1; end
          6'h0D: begin valid = 1'b1; alu = A_OR;  z = 1'b1; end
          default: ;
        endcase
`endif
        if (!valid) pend_ill = 1'b1;
        else begin
          c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.contr = alu; c.zext = z;
          emit(c, rnd(), 1'b1);
          c = '0; c.rw = 1'b1; emit(c, rnd(), 1'b1);
          pend_ret = 1'b1;
        end
      end
    endcase
  endtask

  // sw stalled in MEMWR, reset asserted on its second cycle: IDLE with no strobes, then FETCH
  task automatic gen_sw_reset();
    ctl_t c;
    cur_op = 6'h2B; cur_fn = 6'($urandom);
    do_fetch(0);
    emit(v_decode(), rnd(), 1'b1);
    c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.contr = A_ADD; emit(c, rnd(), 1'b1);
    c = '0; c.mwr = 1'b1; c.iord = 1'b1;
    emit(c, 1'b0, 1'b1);
    emit(c, 1'b0, 1'b0);
    pend_ret = 1'b0; pend_ill = 1'b0; pend_err = 1'b0;
    emit('0, rnd(), 1'b1);
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 12))
      0, 1, 2: return 6'h00;
      3:       return 6'h23;
      4:       return 6'h2B;
      5:       return 6'h04;
      6:       return 6'h02;
      7:       return 6'h08;
      8:       return 6'h0A;
      9:       return 6'h0C;
      10:      return 6'h0D;
      11:      return 6'h3F;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(0, 6))
      0:       return 6'h20;
      1:       return 6'h22;
      2:       return 6'h24;
      3:       return 6'h25;
      4:       return 6'h27;
      5:       return 6'h2A;
      default: return 6'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    ctl_t a, e;
    if (running) begin
      a.contr = bus.contr;       a.src_a = bus.alu_src_a;  a.src_b = bus.alu_src_b;
      a.zext  = bus.imm_zext;    a.iord  = bus.iord;       a.mrd   = bus.mem_read;
      a.mwr   = bus.mem_write;   a.irw   = bus.ir_write;   a.pcw   = bus.pc_write;
      a.pcwc  = bus.pc_write_cond; a.pcsrc = bus.pc_source; a.rdst = bus.reg_dst;
      a.m2r   = bus.mem_to_reg;  a.rw    = bus.reg_write;  a.ret   = bus.retire;
      a.ill   = bus.illegal;     a.err   = bus.mem_err;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cycle %0d underflow: actual %h, no expected entry", cyc, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL cycle %0d ctl: actual %h expected %h (op %h fn %h)",
                   cyc, a, e, bus.opcode, bus.funct);
        end
      end
      cyc++;
    end else if (drv_done && !mon_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: actual %0d entries, required 0", exp_q.size());
      end
      mon_done = 1'b1;
    end
  end

  initial begin
    stim_t s;
    emit('0, 1'b0, 1'b1);                       // IDLE after reset
    gen_instr(6'h00, 6'h22, 0, 0);              // sub
    gen_instr(6'h23, 6'h11, 0, 3);              // lw, 3 wait cycles
    gen_instr(6'h04, 6'h00, 0, 0);              // beq
    gen_instr(6'h02, 6'h05, 0, 0);              // j
    gen_instr(6'h00, 6'h2A, T, 0);              // fetch timeout then slt
    gen_instr(6'h23, 6'h00, T - 1, T - 1);      // ready on final allowed cycle
    gen_instr(6'h23, 6'h00, 0, T);              // lw aborted
    gen_instr(6'h2B, 6'h00, 0, T);              // sw aborted
    gen_instr(6'h2B, 6'h00, 0, 2);              // sw
    gen_instr(6'h3F, 6'h20, 0, 0);              // illegal opcode
    gen_instr(6'h00, 6'h00, 0, 0);              // illegal funct
    gen_instr(6'h0D, 6'h00, 0, 0);              // ori
    gen_sw_reset();
    for (int i = 0; i < 200; i++) gen_instr(pick_op(), pick_fn(), pick_delay(), pick_delay());
    gen_sw_reset();
    cur_op = 6'h00; cur_fn = 6'h00;
    emit(v_fetch(1'b0), 1'b0, 1'b1);            // trailing cycle carries the last pulse

    bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    running = 1'b1;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      rst_n = s.rn; bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.rdy;
      @(posedge clk);
      #1;
    end
    running  = 1'b0;
    drv_done = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
